// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue.
package fetch_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  localparam int IFQ_LANES = 2;

  // Lanes actually pushed for a given in_valid pattern; 2'b10 counts as nothing.
  function automatic logic [1:0] lane_cnt(input logic [1:0] v);
    case (v)
      2'b01:   lane_cnt = 2'd1;
      2'b11:   lane_cnt = 2'd2;
      default: lane_cnt = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction FIFO between fetch and decode.
// Pointers carry a wrap bit so count = tail - head covers empty and full.
// Optional feature macro: IFQ_BYPASS_EN (empty-queue push forwarded to out_* in the same cycle).
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [31:0]            in_pc,
  input  logic [63:0]            in_inst,
  output logic                   in_ready,
  output logic [1:0]             out_valid,
  output logic [63:0]            out_pc,
  output logic [63:0]            out_inst,
  input  logic [1:0]             pop_num,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  fetch_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;

  fetch_entry_t [IFQ_LANES-1:0] w_in_entry;
  logic [PW-1:0] w_count;
  logic [1:0]    w_push_num;
  logic [1:0]    w_pushed;
  logic [1:0]    w_st_valid;
  logic [1:0]    w_avail;
  logic [1:0]    w_popped;
  logic [1:0]    w_wr_num;
  logic [1:0]    w_head_adv;
  logic          w_wr_shift;
  fetch_entry_t  w_wr_lane0;
  logic [IW-1:0] w_head_idx;
  logic [IW-1:0] w_head1_idx;
  logic [IW-1:0] w_tail_idx;
  logic [IW-1:0] w_tail1_idx;

  assign w_count     = r_tail - r_head;
  assign count       = w_count;
  assign in_ready    = (w_count <= PW'(DEPTH - 2));
  assign w_push_num  = lane_cnt(in_valid);
  assign w_pushed    = (in_ready && !flush) ? w_push_num : 2'd0;
  assign w_in_entry[0] = '{pc: in_pc,         inst: in_inst[31:0]};
  assign w_in_entry[1] = '{pc: in_pc + 32'd4, inst: in_inst[63:32]};
  assign w_head_idx  = r_head[IW-1:0];
  assign w_head1_idx = w_head_idx + IW'(1);
  assign w_tail_idx  = r_tail[IW-1:0];
  assign w_tail1_idx = w_tail_idx + IW'(1);
  assign w_st_valid  = {(w_count >= PW'(2)), (w_count != '0)};

`ifdef IFQ_BYPASS_EN
  logic w_byp;
  assign w_byp = (w_count == '0) && !flush;

  // Empty queue forwards the incoming lanes straight to decode.
  always_comb begin
    out_valid = w_st_valid;
    out_pc    = {r_mem[w_head1_idx].pc,   r_mem[w_head_idx].pc};
    out_inst  = {r_mem[w_head1_idx].inst, r_mem[w_head_idx].inst};
    if (w_byp) begin
      out_valid = {w_push_num == 2'd2, w_push_num != 2'd0};
      out_pc    = {w_in_entry[1].pc,   w_in_entry[0].pc};
      out_inst  = {w_in_entry[1].inst, w_in_entry[0].inst};
    end
  end

  // Bypassed lanes consumed this cycle are never stored; the rest land at tail.
  always_comb begin
    w_wr_num   = w_pushed;
    w_head_adv = w_popped;
    w_wr_shift = 1'b0;
    if (w_byp) begin
      w_wr_num   = w_pushed - w_popped;
      w_head_adv = 2'd0;
      w_wr_shift = (w_popped != 2'd0);
    end
  end
`else
  // Outputs come from storage only; no combinational in->out path.
  always_comb begin
    out_valid = w_st_valid;
    out_pc    = {r_mem[w_head1_idx].pc,   r_mem[w_head_idx].pc};
    out_inst  = {r_mem[w_head1_idx].inst, r_mem[w_head_idx].inst};
  end

  assign w_wr_num   = w_pushed;
  assign w_head_adv = w_popped;
  assign w_wr_shift = 1'b0;
`endif

  assign w_avail    = out_valid[1] ? 2'd2 : (out_valid[0] ? 2'd1 : 2'd0);
  // Over-pop is clamped to what decode can actually see.
  assign w_popped   = flush ? 2'd0 : ((pop_num > w_avail) ? w_avail : pop_num);
  assign w_wr_lane0 = w_wr_shift ? w_in_entry[1] : w_in_entry[0];

  // Pointer update: reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + PW'(w_head_adv);
      r_tail <= r_tail + PW'(w_wr_num);
    end
  end

  // Storage write: lane 0 (or the surviving bypass lane) at tail, lane 1 at tail+1.
  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      if (w_wr_num != 2'd0) r_mem[w_tail_idx]  <= w_wr_lane0;
      if (w_wr_num == 2'd2) r_mem[w_tail1_idx] <= w_in_entry[1];
    end
  end

`ifndef SYNTHESIS
  // Flag illegal producer/consumer behaviour in simulation.
  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      assert (in_valid != 2'b10);
      assert (pop_num <= w_avail);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_pc;
  logic [63:0] in_inst;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  pop_num;
  logic [$clog2(DEPTH):0] count;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .pop_num(pop_num), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ment_t;
  typedef struct {
    int cnt; logic rdy; logic [1:0] vld;
    logic [31:0] pc0, pc1, inst0, inst1;
  } exp_t;

  ment_t mq[$];
  exp_t  sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int nl(input logic [1:0] v);
    return (v == 2'b11) ? 2 : (v == 2'b01) ? 1 : 0;
  endfunction

  // How many entries decode may legally take this cycle.
  function automatic int avail(input logic fl, input logic [1:0] iv);
`ifdef IFQ_BYPASS_EN
    if (mq.size() == 0 && !fl) return nl(iv);
`endif
    return (mq.size() > 2) ? 2 : mq.size();
  endfunction

  // Called at a negedge: drive inputs, log expected outputs, advance model at posedge.
  task automatic step(input logic fl, input logic [1:0] iv, input logic [31:0] pc,
                      input logic [63:0] ins, input int pn);
    exp_t e;
    ment_t l0, l1;
    int sz, np;
    flush = fl; in_valid = iv; in_pc = pc; in_inst = ins; pop_num = 2'(pn);
    sz = mq.size();
    l0.pc = pc;       l0.inst = ins[31:0];
    l1.pc = pc + 32'd4; l1.inst = ins[63:32];
    e.cnt = sz; e.rdy = (sz <= DEPTH - 2);
    e.vld = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00;
    e.pc0 = 'x; e.pc1 = 'x; e.inst0 = 'x; e.inst1 = 'x;
    if (sz >= 1) begin e.pc0 = mq[0].pc; e.inst0 = mq[0].inst; end
    if (sz >= 2) begin e.pc1 = mq[1].pc; e.inst1 = mq[1].inst; end
`ifdef IFQ_BYPASS_EN
    if (sz == 0 && !fl) begin
      e.vld = (nl(iv) == 2) ? 2'b11 : (nl(iv) == 1) ? 2'b01 : 2'b00;
      e.pc0 = l0.pc; e.inst0 = l0.inst; e.pc1 = l1.pc; e.inst1 = l1.inst;
    end
`endif
    sb.push_back(e);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      np = (sz <= DEPTH - 2) ? nl(iv) : 0;
      if (np >= 1) mq.push_back(l0);
      if (np >= 2) mq.push_back(l1);
      for (int k = 0; k < pn; k++) void'(mq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 32'h0, 64'h0, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; flush = 1'b0; in_valid = 2'b00; pop_num = 2'd0;
    @(posedge clk);
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: pops one expected record per driven cycle and compares outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("count", 32'(count), 32'(e.cnt));
        chk("in_ready", 32'(in_ready), 32'(e.rdy));
        chk("out_valid", 32'(out_valid), 32'(e.vld));
        if (e.vld[0]) begin
          chk("pc0", out_pc[31:0], e.pc0);
          chk("inst0", out_inst[31:0], e.inst0);
        end
        if (e.vld[1]) begin
          chk("pc1", out_pc[63:32], e.pc1);
          chk("inst1", out_inst[63:32], e.inst1);
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    logic [1:0]  iv;
    logic        fl;
    resetn = 1'b0; flush = 1'b0; in_valid = 2'b00; in_pc = '0; in_inst = '0; pop_num = '0;
    @(negedge clk);
    do_reset();

    // Basic push, visible on the outputs.
    step(1'b0, 2'b11, 32'h8000_0000, {32'h2, 32'h1}, 0);
    idle();

    // Fill to full, then one dropped push.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b0, 2'b11, 32'h1000 + 32'(i * 8), {32'(100 + 2 * i + 1), 32'(100 + 2 * i)}, 0);
    step(1'b0, 2'b11, 32'hDEAD_0000, {32'hBAD1, 32'hBAD0}, 0);
    idle();

    // Push 2 + pop 2 at count 14 across the pointer wrap.
    step(1'b0, 2'b00, 32'h0, 64'h0, 2);
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'b11, 32'h2000 + 32'(i * 8), {32'(200 + 2 * i + 1), 32'(200 + 2 * i)}, 2);
    idle();

    // Drain to 5, then single pops down to empty.
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 32'h0, 64'h0, 2);
    step(1'b0, 2'b00, 32'h0, 64'h0, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 32'h0, 64'h0, 1);
    idle();

    // Flush at count 9 with push and pop asserted.
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'b11, 32'h3000 + 32'(i * 8), {32'(300 + 2 * i + 1), 32'(300 + 2 * i)}, 0);
    step(1'b0, 2'b01, 32'h3040, {32'h0, 32'h308}, 0);
    step(1'b1, 2'b11, 32'h3048, {32'h30A, 32'h309}, 2);
    idle();

`ifdef IFQ_BYPASS_EN
    // Empty-queue bypass with partial consumption.
    step(1'b0, 2'b11, 32'h4000, {32'h401, 32'h400}, 1);
    idle();
    step(1'b0, 2'b00, 32'h0, 64'h0, 1);
`endif

    // Random traffic, with one mid-stream reset.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      fl  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       iv = 2'b00;
        1:       iv = 2'b01;
        default: iv = 2'b11;
      endcase
      rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step(fl, iv, rpc, {$urandom, $urandom}, $urandom_range(0, avail(fl, iv)));
    end
    idle();

    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
